// File: rtl/dsp_pkg.sv
// Shared widths, control bundle and OPMODE bit map for the DSP multiply-accumulate slice.
package dsp_pkg;

    localparam int AW_DEF = 18;
    localparam int PW_DEF = 48;

    typedef struct packed {
        logic pre_en;
        logic pre_sub;
        logic acc_en;
        logic post_sub;
    } dsp_ctrl_t;

    // Bit positions of these controls inside a DSP48A1 OPMODE word.
    localparam int OPM_POST_SUB_BIT = 7;
    localparam int OPM_PRE_SUB_BIT  = 6;
    localparam int OPM_PRE_EN_BIT   = 4;
    localparam int OPM_ZMUX_P_BIT   = 3;

    function automatic logic [7:0] ctrl_to_opmode(input dsp_ctrl_t c);
        logic [7:0] opm;
        opm                   = 8'h01;
        opm[OPM_POST_SUB_BIT] = c.post_sub;
        opm[OPM_PRE_SUB_BIT]  = c.pre_sub;
        opm[OPM_PRE_EN_BIT]   = c.pre_en;
        opm[OPM_ZMUX_P_BIT]   = c.acc_en;
        return opm;
    endfunction

endpackage

// File: rtl/dsp_mult_acc_if.sv
// Operand, control and result bundle between the operand register stage, this core and the output stage.
interface dsp_mult_acc_if
    import dsp_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int PW = PW_DEF
) ();

    logic            CE;
    logic            in_valid;
    logic [AW-1:0]   a;
    logic [AW-1:0]   b;
    logic [AW-1:0]   d;
    logic            pre_en;
    logic            pre_sub;
    logic            acc_en;
    logic            post_sub;
    logic [2*AW-1:0] m;
    logic [PW-1:0]   p;
    logic            carryout;
    logic            out_valid;

    modport master (
        output CE, in_valid, a, b, d, pre_en, pre_sub, acc_en, post_sub,
        input  m, p, carryout, out_valid
    );

    modport slave (
        input  CE, in_valid, a, b, d, pre_en, pre_sub, acc_en, post_sub,
        output m, p, carryout, out_valid
    );

endinterface

// File: rtl/dsp_mult_acc_pipe_reg.sv
// Width-parameterised pipeline register with clock enable and asynchronous active-high clear.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (ce_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/dsp_mult_acc.sv
// Three-stage pre-add / multiply / post-add accumulate core with a valid bit riding alongside the data.
module dsp_mult_acc
    import dsp_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          RST,
    dsp_mult_acc_if.slave bus
);

    dsp_ctrl_t       ctrl_in;
    logic [AW-1:0]   pre_sum;
    logic [AW-1:0]   b1_d;
    logic [AW-1:0]   a1_q;
    logic [AW-1:0]   b1_q;
    logic [2*AW-1:0] m_d;
    logic [2*AW-1:0] m_q;
    logic [PW:0]     x_ext;
    logic [PW:0]     m_ext;
    logic [PW:0]     r_d;
    logic [PW-1:0]   p_q;
    logic            co_q;
    logic            ov_q;
    logic            v2_q;
    logic            acc2_q;
    logic            post2_q;

    // {valid, acc_en, post_sub} travel together through stages 1 and 2.
    logic [2:0][2:0] vc_chain;

    assign ctrl_in = '{pre_en:   bus.pre_en,
                       pre_sub:  bus.pre_sub,
                       acc_en:   bus.acc_en,
                       post_sub: bus.post_sub};

    assign pre_sum     = ctrl_in.pre_sub ? (bus.d - bus.b) : (bus.d + bus.b);
    assign b1_d        = ctrl_in.pre_en ? pre_sum : bus.b;
    assign vc_chain[0] = {bus.in_valid, ctrl_in.acc_en, ctrl_in.post_sub};

    pipe_reg #(.W(AW)) u_a1 (.clk(clk), .rst(RST), .ce_i(bus.CE), .d_i(bus.a), .q_o(a1_q));
    pipe_reg #(.W(AW)) u_b1 (.clk(clk), .rst(RST), .ce_i(bus.CE), .d_i(b1_d),  .q_o(b1_q));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vc
            pipe_reg #(.W(3)) u_vc (
                .clk (clk),
                .rst (RST),
                .ce_i(bus.CE),
                .d_i (vc_chain[gi]),
                .q_o (vc_chain[gi+1])
            );
        end
    endgenerate

    assign {v2_q, acc2_q, post2_q} = vc_chain[2];

    assign m_d = {{AW{1'b0}}, a1_q} * {{AW{1'b0}}, b1_q};

    pipe_reg #(.W(2*AW)) u_m (.clk(clk), .rst(RST), .ce_i(bus.CE), .d_i(m_d), .q_o(m_q));

    // One extra bit on top of P captures carry on add and borrow on subtract.
    assign x_ext = acc2_q ? {1'b0, p_q} : '0;
    assign m_ext = {{(PW + 1 - 2*AW){1'b0}}, m_q};
    assign r_d   = post2_q ? (x_ext - m_ext) : (x_ext + m_ext);

    pipe_reg #(.W(PW+1)) u_p (
        .clk (clk),
        .rst (RST),
        .ce_i(bus.CE & v2_q),
        .d_i (r_d),
        .q_o ({co_q, p_q})
    );

    pipe_reg #(.W(1)) u_ov (.clk(clk), .rst(RST), .ce_i(bus.CE), .d_i(v2_q), .q_o(ov_q));

    assign bus.m         = m_q;
    assign bus.p         = p_q;
    assign bus.carryout  = co_q;
    assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_dsp_mult_acc.sv
// Scoreboard bench for dsp_mult_acc: directed pre-add, accumulate, wrap, carry/borrow, CE hold, async reset, random stream.
module tb_dsp_mult_acc;

    typedef struct {
        logic [47:0] p;
        logic        co;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   ce_seen;
    exp_t sb_q[$];
    logic [47:0] mdl_p;

    dsp_mult_acc_if bus ();

    dsp_mult_acc dut (
        .clk(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    always @(posedge clk) ce_seen = bus.CE && !rst;

    // Scoreboard: each enabled-edge result is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && ce_seen && bus.out_valid) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected out_valid p=%h with no pending operation", bus.p);
            end else begin
                e = sb_q.pop_front();
                if (bus.p !== e.p || bus.carryout !== e.co) begin
                    failures++;
                    $display("FAIL sb_result got p=%h co=%b want p=%h co=%b",
                             bus.p, bus.carryout, e.p, e.co);
                end else begin
                    $display("result p=%h co=%b", bus.p, bus.carryout);
                end
            end
        end
    end

    task automatic issue(input logic [17:0] ia, input logic [17:0] ib, input logic [17:0] id,
                         input logic ipe, input logic ipsub, input logic iacc, input logic ipost);
        logic [17:0] b1;
        logic [35:0] mm;
        logic [48:0] x;
        logic [48:0] r;
        exp_t        e;
        if (ipe) b1 = ipsub ? id - ib : id + ib;
        else     b1 = ib;
        mm    = 36'(ia) * 36'(b1);
        x     = iacc ? {1'b0, mdl_p} : 49'd0;
        r     = ipost ? x - {13'd0, mm} : x + {13'd0, mm};
        mdl_p = r[47:0];
        e.p   = r[47:0];
        e.co  = r[48];
        sb_q.push_back(e);
        bus.a        = ia;
        bus.b        = ib;
        bus.d        = id;
        bus.pre_en   = ipe;
        bus.pre_sub  = ipsub;
        bus.acc_en   = iacc;
        bus.post_sub = ipost;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want 0", sb_q.size());
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks += 4;
        if (bus.m !== 36'd0)      begin failures++; $display("FAIL reset_m got %h want 0", bus.m); end
        if (bus.p !== 48'd0)      begin failures++; $display("FAIL reset_p got %h want 0", bus.p); end
        if (bus.carryout !== 1'b0) begin failures++; $display("FAIL reset_co got %b want 0", bus.carryout); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_ov got %b want 0", bus.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_preadd();
        issue(18'd3, 18'd5, 18'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        checks += 2;
        if (bus.m !== 36'd45)       begin failures++; $display("FAIL basic_m got %0d want 45", bus.m); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_early got %b want 0", bus.out_valid); end
        step();
        checks += 3;
        if (bus.p !== 48'd45)        begin failures++; $display("FAIL basic_p got %0d want 45", bus.p); end
        if (bus.carryout !== 1'b0)  begin failures++; $display("FAIL basic_co got %b want 0", bus.carryout); end
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_ov got %b want 1", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_pulse got %b want 0", bus.out_valid); end
        drain();
    endtask

    task automatic test_accumulate();
        issue(18'd3, 18'd5, 18'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(18'd3, 18'd5, 18'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        checks++;
        if (bus.p !== 48'd45) begin failures++; $display("FAIL acc_first got %0d want 45", bus.p); end
        step();
        checks += 2;
        if (bus.p !== 48'd90)        begin failures++; $display("FAIL acc_second got %0d want 90", bus.p); end
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL acc_ov got %b want 1", bus.out_valid); end
        drain();
    endtask

    task automatic test_presub_wrap();
        issue(18'd1, 18'd5, 18'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.m !== 36'd262141) begin failures++; $display("FAIL presub_m got %0d want 262141", bus.m); end
        step();
        checks++;
        if (bus.p !== 48'd262141) begin failures++; $display("FAIL presub_p got %0d want 262141", bus.p); end
        drain();
    endtask

    task automatic test_carry_borrow();
        issue(18'd1, 18'd1, 18'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(18'd1, 18'd1, 18'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(18'd1, 18'd1, 18'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks += 2;
        if (bus.p !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL preload_p got %h want ffffffffffff", bus.p); end
        if (bus.carryout !== 1'b1)       begin failures++; $display("FAIL preload_co got %b want 1", bus.carryout); end
        step();
        checks += 2;
        if (bus.p !== 48'd0)       begin failures++; $display("FAIL carry_p got %h want 0", bus.p); end
        if (bus.carryout !== 1'b1) begin failures++; $display("FAIL carry_co got %b want 1", bus.carryout); end
        step();
        checks += 2;
        if (bus.p !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL borrow_p got %h want ffffffffffff", bus.p); end
        if (bus.carryout !== 1'b1)       begin failures++; $display("FAIL borrow_co got %b want 1", bus.carryout); end
        drain();
    endtask

    task automatic test_ce_hold();
        issue(18'd7, 18'd3,   18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(18'd2, 18'd100, 18'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(18'd5, 18'd5,   18'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.CE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks += 3;
            if (bus.p !== 48'd21)        begin failures++; $display("FAIL ce_hold_p cyc=%0d got %0d want 21", i, bus.p); end
            if (bus.m !== 36'd200)       begin failures++; $display("FAIL ce_hold_m cyc=%0d got %0d want 200", i, bus.m); end
            if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ce_hold_ov cyc=%0d got %b want 1", i, bus.out_valid); end
        end
        bus.CE = 1'b1;
        step();
        checks++;
        if (bus.p !== 48'd221) begin failures++; $display("FAIL ce_resume2 got %0d want 221", bus.p); end
        step();
        checks++;
        if (bus.p !== 48'd246) begin failures++; $display("FAIL ce_resume3 got %0d want 246", bus.p); end
        drain();
    endtask

    task automatic test_async_reset();
        issue(18'd4, 18'd4, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(18'd2, 18'd3, 18'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(18'd9, 18'd9, 18'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks += 4;
        if (bus.p !== 48'd0)        begin failures++; $display("FAIL arst_p got %h want 0", bus.p); end
        if (bus.m !== 36'd0)        begin failures++; $display("FAIL arst_m got %h want 0", bus.m); end
        if (bus.carryout !== 1'b0)  begin failures++; $display("FAIL arst_co got %b want 0", bus.carryout); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_ov got %b want 0", bus.out_valid); end
        sb_q.delete();
        mdl_p = 48'd0;
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_stale_ov got %b want 0", bus.out_valid); end
        issue(18'd3, 18'd3, 18'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            issue(18'($urandom), 18'($urandom), 18'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        mdl_p        = 48'd0;
        bus.CE       = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.d        = '0;
        bus.pre_en   = 1'b0;
        bus.pre_sub  = 1'b0;
        bus.acc_en   = 1'b0;
        bus.post_sub = 1'b0;
        test_reset();
        test_basic_preadd();
        test_accumulate();
        test_presub_wrap();
        test_carry_borrow();
        test_ce_hold();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
